// File: rtl/rpn_pkg.sv
// Shared types for the RPN sequencer: FSM states, op codes, instruction layout
// and error codes.
package rpn_pkg;

  typedef enum logic [2:0] {
    IDLE, CLEAR, FETCH, SETUP, STEP, SETTLE, DONE, ERR
  } state_t;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_NEG = 2'd1;
  localparam logic [1:0] OP_ADD = 2'd2;
  localparam logic [1:0] OP_MUL = 2'd3;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;

  typedef struct packed {
    logic        push;
    logic [1:0]  op;
    logic [15:0] d;
  } instr_t;

  // Operands an op consumes from the stack.
  function automatic logic [9:0] op_min_depth(input logic [1:0] op);
    case (op)
      OP_NOP:  return 10'd0;
      OP_NEG:  return 10'd1;
      default: return 10'd2;
    endcase
  endfunction

endpackage

// File: rtl/rpn_depth_check.sv
// Combinational legality check of one command against the current stack depth.
module rpn_depth_check
  import rpn_pkg::*;
#(
  parameter int DEPTH = 1000
) (
  input  instr_t     cmd,
  input  logic [9:0] stk_cnt,
  output logic       ok,
  output logic [1:0] code
);

  always_comb begin
    ok   = 1'b1;
    code = ERR_NONE;
    if (cmd.push) begin
      if (stk_cnt >= 10'(DEPTH)) begin
        ok   = 1'b0;
        code = ERR_OVERFLOW;
      end
    end else if (stk_cnt < op_min_depth(cmd.op)) begin
      ok   = 1'b0;
      code = ERR_UNDERFLOW;
    end
  end

endmodule

// File: rtl/rpn_sequencer.sv
// Steps an external RPN stack datapath through a program, 4 cycles per instruction.
// Define RPN_SEQ_DEPTH_CHECK_EN to trap under/overflow before issuing a command.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int DEPTH = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [PC_W-1:0] prog_len,
  output logic [PC_W-1:0] instr_addr,
  input  logic [18:0]     instr_data,
  output logic            stk_nrst,
  output logic            stk_step,
  output logic            stk_push,
  output logic [1:0]      stk_op,
  output logic [15:0]     stk_d,
  input  logic [9:0]      stk_cnt,
  input  logic [15:0]     stk_out,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [15:0]     result
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  instr_t          cmd_q, cmd_d;
  logic            stk_step_q, stk_step_d;
  logic            stk_nrst_q, stk_nrst_d;
  logic            done_q, done_d;
  logic [15:0]     result_q, result_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            chk_ok;
  logic [1:0]      chk_code;

  rpn_depth_check #(.DEPTH(DEPTH)) u_depth_check (
    .cmd     (cmd_q),
    .stk_cnt (stk_cnt),
    .ok      (chk_ok),
    .code    (chk_code)
  );

`ifndef RPN_SEQ_DEPTH_CHECK_EN
  logic unused_chk;
  assign unused_chk = ^{chk_ok, chk_code};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = CLEAR;
      CLEAR:  state_d = (prog_len == '0) ? DONE : FETCH;
      FETCH:  state_d = SETUP;
`ifdef RPN_SEQ_DEPTH_CHECK_EN
      SETUP:  state_d = chk_ok ? STEP : ERR;
`else
      SETUP:  state_d = STEP;
`endif
      STEP:   state_d = SETTLE;
      SETTLE: state_d = ((pc_q + PC_W'(1)) == prog_len) ? DONE : FETCH;
      DONE:   state_d = IDLE;
      ERR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over whatever the running instruction would do next.
    if (abort && busy) state_d = IDLE;
  end

  always_comb begin
    busy     = 1'b0;
    stk_push = 1'b0;
    stk_op   = OP_NOP;
    stk_d    = '0;
    case (state_q)
      CLEAR, FETCH: busy = 1'b1;
      SETUP, STEP, SETTLE: begin
        busy     = 1'b1;
        stk_push = cmd_q.push;
        stk_op   = cmd_q.op;
        stk_d    = cmd_q.d;
      end
      default: ;
    endcase
  end

  // Step and stack-clear strobes are registered from the next state so they
  // line up exactly with STEP and CLEAR and come out glitch-free.
  always_comb begin
    pc_d       = pc_q;
    cmd_d      = cmd_q;
    result_d   = result_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    stk_step_d = (state_d == STEP);
    stk_nrst_d = (state_d != CLEAR);
    done_d     = (state_q == DONE);
    case (state_q)
      CLEAR: begin
        pc_d       = '0;
        err_d      = 1'b0;
        err_code_d = ERR_NONE;
      end
      FETCH:  cmd_d = instr_t'(instr_data);
`ifdef RPN_SEQ_DEPTH_CHECK_EN
      SETUP: if (state_d == ERR) begin
        err_d      = 1'b1;
        err_code_d = chk_code;
      end
`endif
      SETTLE: if (state_d != IDLE) pc_d = pc_q + PC_W'(1);
      DONE:   result_d = stk_out;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      cmd_q      <= '0;
      stk_step_q <= 1'b0;
      stk_nrst_q <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      pc_q       <= pc_d;
      cmd_q      <= cmd_d;
      stk_step_q <= stk_step_d;
      stk_nrst_q <= stk_nrst_d;
      done_q     <= done_d;
      result_q   <= result_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign instr_addr = pc_q;
  assign stk_step   = stk_step_q;
  assign stk_nrst   = stk_nrst_q;
  assign done       = done_q;
  assign result     = result_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Self-checking bench for rpn_sequencer: directed scenarios plus random programs
// scored against a queue-based RPN evaluator; a behavioural stack stands in for the datapath.
module tb_rpn_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [7:0]  prog_len;
  logic [7:0]  instr_addr;
  logic [18:0] instr_data;
  logic        stk_nrst, stk_step, stk_push;
  logic [1:0]  stk_op;
  logic [15:0] stk_d;
  logic [9:0]  stk_cnt;
  logic [15:0] stk_out;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [15:0] result;

  int errors = 0;
  int checks = 0;

  rpn_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_len(prog_len),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .stk_nrst(stk_nrst), .stk_step(stk_step), .stk_push(stk_push),
    .stk_op(stk_op), .stk_d(stk_d), .stk_cnt(stk_cnt), .stk_out(stk_out),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .result(result)
  );

  always #5 clk = ~clk;

  logic [18:0] prog [0:255];
  assign instr_data = prog[instr_addr];

  // Behavioural stack datapath.
  logic [15:0] smem [0:1023];
  logic [9:0]  scnt;
  always @(posedge clk) begin
    if (!stk_nrst) scnt <= '0;
    else if (stk_step) begin
      if (stk_push) begin
        smem[scnt] <= stk_d;
        scnt <= scnt + 10'd1;
      end else if (stk_op == 2'd1 && scnt >= 10'd1) begin
        smem[scnt-10'd1] <= -smem[scnt-10'd1];
      end else if (stk_op == 2'd2 && scnt >= 10'd2) begin
        smem[scnt-10'd2] <= smem[scnt-10'd2] + smem[scnt-10'd1];
        scnt <= scnt - 10'd1;
      end else if (stk_op == 2'd3 && scnt >= 10'd2) begin
        smem[scnt-10'd2] <= smem[scnt-10'd2] * smem[scnt-10'd1];
        scnt <= scnt - 10'd1;
      end
    end
  end
  assign stk_cnt = scnt;
  assign stk_out = (scnt == 10'd0) ? 16'h0 : smem[scnt-10'd1];

  function automatic logic [18:0] mk(input logic p, input logic [1:0] op, input logic [15:0] d);
    return {p, op, d};
  endfunction

  // Reference: evaluate the program as RPN on a queue.
  function automatic logic [15:0] ref_eval(input int n, output int depth);
    logic [15:0] st[$];
    logic [15:0] a, b;
    logic [18:0] w;
    for (int i = 0; i < n; i++) begin
      w = prog[i];
      if (w[18]) st.push_back(w[15:0]);
      else if (w[17:16] == 2'd1 && st.size() >= 1) begin
        a = st.pop_back();
        st.push_back(16'(0 - a));
      end else if (w[17:16] >= 2'd2 && st.size() >= 2) begin
        a = st.pop_back();
        b = st.pop_back();
        st.push_back((w[17:16] == 2'd2) ? 16'(b + a) : 16'(b * a));
      end
    end
    depth = st.size();
    return (st.size() == 0) ? 16'h0 : st[st.size()-1];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a run and follow it until done, an error stop, or the cycle budget.
  task automatic run(input int len, input int budget, output int cyc, output bit got_done,
                     output int steps, output int nrst_lows);
    prog_len = 8'(len);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; got_done = 1'b0; steps = 0; nrst_lows = 0;
    if (stk_step) steps++;
    if (!stk_nrst) nrst_lows++;
    while (cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (stk_step) steps++;
      if (!stk_nrst) nrst_lows++;
      if (done) begin got_done = 1'b1; break; end
      if (!busy && err) break;
    end
    $display("run len=%0d cycles=%0d done=%0d steps=%0d result=%h err=%0d code=%0d",
             len, cyc, got_done, steps, result, err, err_code);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, steps, nl, dep, len, d, seen;
    bit gd;
    logic [15:0] expv, held;

    rst = 1'b1; start = 1'b0; abort = 1'b0; prog_len = '0;
    for (int i = 0; i < 256; i++) prog[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {busy, done, err, err_code, stk_step, stk_nrst, stk_push, stk_op}, 0);
    check("rst_result", result, 0);
    check("rst_stk_d", stk_d, 0);
    check("rst_addr", instr_addr, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("nrst_after_rst", stk_nrst, 1);

    // push 3, push 4, ADD
    prog[0] = mk(1, 0, 16'd3); prog[1] = mk(1, 0, 16'd4); prog[2] = mk(0, 2, 16'd0);
    run(3, 40, cyc, gd, steps, nl);
    check("add_done", gd, 1);
    check("add_latency", cyc, 14);
    check("add_result", result, 16'd7);
    check("add_cnt", stk_cnt, 1);
    check("add_steps", steps, 3);
    check("add_nrst_lows", nl, 1);
    @(posedge clk); #1;
    check("done_pulse_width", done, 0);
    check("result_hold", result, 16'd7);

    // push 5, NEG
    prog[0] = mk(1, 0, 16'd5); prog[1] = mk(0, 1, 16'd0);
    run(2, 40, cyc, gd, steps, nl);
    check("neg_done", gd, 1);
    check("neg_result", result, 16'hFFFB);
    check("neg_err", err, 0);

    // empty program
    run(0, 20, cyc, gd, steps, nl);
    check("empty_done", gd, 1);
    check("empty_latency", cyc, 2);
    check("empty_result", result, 0);
    check("empty_nrst_lows", nl, 1);
    check("empty_steps", steps, 0);

    // lone ADD on an empty stack
    prog[0] = mk(0, 2, 16'd0);
    run(1, 20, cyc, gd, steps, nl);
`ifdef RPN_SEQ_DEPTH_CHECK_EN
    check("under_done", gd, 0);
    check("under_err", err, 1);
    check("under_code", err_code, 1);
    check("under_steps", steps, 0);
    @(posedge clk); #1;
    check("under_addr", instr_addr, 0);
    check("under_idle", busy, 0);
    check("under_sticky", {err, err_code}, 3'b101);
`else
    check("nochk_done", gd, 1);
    check("nochk_steps", steps, 1);
    check("nochk_err", {err, err_code}, 0);
`endif
    run(0, 20, cyc, gd, steps, nl);
    check("err_cleared", {err, err_code}, 0);

    // abort during STEP of the second instruction
    prog[0] = mk(1, 0, 16'd3); prog[1] = mk(1, 0, 16'd4); prog[2] = mk(0, 2, 16'd0);
    held = result;
    prog_len = 8'd3;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    steps = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (stk_step) steps++;
      if (steps == 2) begin seen = 1; break; end
    end
    check("abort_reached_step2", seen, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_step", stk_step, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    check("abort_no_done", seen, 0);
    check("abort_result_held", result, held);
    $display("abort step2 busy=%0d done_seen=%0d result=%h", busy, seen, result);
    run(3, 40, cyc, gd, steps, nl);
    check("rerun_latency", cyc, 14);
    check("rerun_result", result, 16'd7);
    check("rerun_steps", steps, 3);

    // asynchronous reset in the middle of SETUP
    prog_len = 8'd3;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (stk_push && !stk_step) begin seen = 1; break; end
    end
    check("setup_reached", seen, 1);
    #2 rst = 1'b1;
    #1;
    check("async_ctrl", {busy, done, err, err_code, stk_step, stk_nrst, stk_push, stk_op}, 0);
    check("async_result", result, 0);
    check("async_stk_d", stk_d, 0);
    check("async_addr", instr_addr, 0);
    $display("async rst mid-SETUP busy=%0d nrst=%0d result=%h", busy, stk_nrst, result);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("async_stack_cleared", stk_cnt, 0);
    check("async_no_done", done, 0);

    // random legal programs
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 10);
      d = 0;
      for (int i = 0; i < len; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (d == 0 || r < 4) begin
          prog[i] = mk(1, 0, 16'($urandom));
          d++;
        end else if (r == 4) prog[i] = mk(0, 0, 16'($urandom));
        else if (r == 5 || d < 2) prog[i] = mk(0, 1, 16'($urandom));
        else begin
          prog[i] = mk(0, (r < 8) ? 2'd2 : 2'd3, 16'($urandom));
          d--;
        end
      end
      expv = ref_eval(len, dep);
      run(len, 100, cyc, gd, steps, nl);
      check("rnd_done", gd, 1);
      check("rnd_latency", cyc, 2 + 4 * len);
      check("rnd_result", result, expv);
      check("rnd_depth", stk_cnt, dep);
      check("rnd_steps", steps, len);
      check("rnd_err", {err, err_code}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rpn_sequencer.md
RPN_SEQUENCER -- requirements
Module: rpn_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter and prog_len width.
REQ-002 SHALL have parameter DEPTH, default 1000, stack capacity checked against stk_cnt.
REQ-003 SHALL have port clk  in  1  single clock; all state on posedge clk.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports start in 1 (begin run), abort in 1 (cancel run), prog_len in PC_W (instruction count).
REQ-006 SHALL have ports instr_addr out PC_W and instr_data in 19; instr_data is combinational read, {push, op[1:0], d[15:0]}.
REQ-007 SHALL have ports stk_nrst out 1, stk_step out 1, stk_push out 1, stk_op out 2 and stk_d out 16, all driving the stack datapath.
REQ-008 SHALL have ports stk_cnt in 10 and stk_out in 16, stack depth and top of stack.
REQ-009 SHALL have ports busy out 1, done out 1 (pulse), err out 1, err_code out 2 (0 none, 1 underflow, 2 overflow) and result out 16.

Function
REQ-010 SHALL implement FSM IDLE, CLEAR, FETCH, SETUP, STEP, SETTLE, DONE, ERR.
REQ-011 SHALL go IDLE->CLEAR on start=1; start SHALL be ignored in all other states.
REQ-012 SHALL drive stk_nrst=0 for exactly one cycle in CLEAR, clear pc, err and err_code, then go to FETCH, or to DONE if prog_len==0.
REQ-013 SHALL, in FETCH, drive instr_addr=pc and register instr_data into the command register.
REQ-014 SHALL, in SETUP, drive stk_push/stk_op/stk_d from the command register and hold them stable through STEP and SETTLE.
REQ-015 SHALL raise stk_step high for exactly one cycle, in STEP only, as a registered output, and hold it low in every other state.
REQ-016 SHALL, in SETTLE, increment pc and go to DONE if pc+1==prog_len, else to FETCH; latency is 4 cycles per instruction.
REQ-017 SHALL set busy=1 in CLEAR through SETTLE, and busy=0 in IDLE, DONE and ERR.
REQ-018 SHALL, in DONE, latch result<=stk_out, pulse done for one cycle and return to IDLE.
REQ-019 SHALL hold result until the next DONE.
REQ-020 SHALL, on abort=1 in any busy state, go to IDLE on the next edge with stk_step=0 and no done pulse; abort SHALL take priority over step completion.
REQ-021 SHALL execute op codes 0=NOP, 1=NEG (needs depth>=1), 2=ADD and 3=MUL (each needs depth>=2); push SHALL take priority over op.
REQ-022 SHALL NOT wrap pc, since prog_len is at most 2^PC_W-1.
REQ-023 SHALL hold err and err_code sticky until the next start.

Reset
REQ-024 SHALL, on rst=1, immediately set state IDLE, pc=0, stk_nrst=0, stk_step=0, stk_push=0, stk_op=0, stk_d=0, busy=0, done=0, err=0, err_code=0, result=0.
REQ-025 SHALL drive stk_nrst=1 from the first edge after rst deasserts, except in CLEAR.
REQ-026 SHALL, when rst asserts mid-run, end the run with no done pulse and clear the stack through stk_nrst.

Configuration
REQ-027 SHALL, with macro RPN_SEQ_DEPTH_CHECK_EN defined, check the command in SETUP before STEP: an op with too little depth, or a push with stk_cnt==DEPTH, SHALL go to ERR with no stk_step pulse and set err=1 and err_code 1 or 2.
REQ-028 SHALL, in ERR, return to IDLE after one cycle, with pc frozen at the faulting instruction.
REQ-029 SHALL, without RPN_SEQ_DEPTH_CHECK_EN, issue every command unchecked; ERR is then unreachable and err/err_code are tied to 0.

Structure
REQ-030 SHALL take from package rpn_pkg: state enum, op-code constants OP_NOP/OP_NEG/OP_ADD/OP_MUL, instr_t packed struct {push, op, d}, and err-code constants.
REQ-031 SHALL implement the depth check in sub-module rpn_depth_check (combinational: instr_t, stk_cnt -> ok, code).

Verification
REQ-032 SHALL cover: program {push 3, push 4, ADD}, start -> done after 14 cycles, result=7, stk_cnt=1.
REQ-033 SHALL cover: {push 5, NEG} -> result=16'hFFFB, err=0.
REQ-034 SHALL cover: {ADD} with RPN_SEQ_DEPTH_CHECK_EN -> err=1, err_code=1, zero stk_step pulses, instr_addr=0.
REQ-035 SHALL cover: prog_len=0 -> done in the 3rd cycle after start, result=0, one stk_nrst low pulse.
REQ-036 SHALL cover: abort during STEP of instruction 2 -> IDLE next cycle, busy=0, no done; a following start reruns from pc=0.
REQ-037 SHALL cover: rst asserted mid-SETUP -> all outputs at reset values asynchronously, before the next clk edge.
